// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, stable-count filter, press/release pulses, sticky events, irq.
// Long-press detection (shared prescaler + per-channel hold counters) is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_multi #(
  parameter int    WIDTH         = 2,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_TICKS    = 500,
  parameter int    LONG_WIDTH    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] events,
  output logic             irq
);

  localparam bit                       ACTIVE_LOW = (POLARITY != "HIGH");
  localparam logic [WIDTH-1:0]         SYNC_IDLE  = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST   = TIMEOUT_WIDTH'(TIMEOUT - 1);

  if (WIDTH < 1 || WIDTH > 32 || TIMEOUT < 2 || TIMEOUT_WIDTH < 1 ||
      LONG_TICKS < 1 || LONG_WIDTH < 1) begin : g_param_err
    $error("debounce_multi: illegal parameter value");
  end

  logic [WIDTH-1:0]         r_sync1;
  logic [WIDTH-1:0]         r_sync2;
  logic [WIDTH-1:0]         r_data;
  logic [WIDTH-1:0]         r_rise;
  logic [WIDTH-1:0]         r_fall;
  logic [WIDTH-1:0]         r_events;
  logic [TIMEOUT_WIDTH-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]         w_norm;
  logic [WIDTH-1:0]         w_toggle;

  assign w_norm = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // A channel flips once its input has disagreed with the debounced state for TIMEOUT consecutive cycles.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_toggle[i] = (w_norm[i] != r_data[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= SYNC_IDLE;
      r_sync2  <= SYNC_IDLE;
      r_data   <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_events <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_norm[i] != r_data[i] && !w_toggle[i]) begin
          r_cnt[i] <= r_cnt[i] + TIMEOUT_WIDTH'(1);
        end else begin
          r_cnt[i] <= '0;
        end
      end
      r_data   <= r_data ^ w_toggle;
      r_rise   <= w_toggle & ~r_data;
      r_fall   <= w_toggle & r_data;
      // A press landing in the same cycle as a clear must survive.
      r_events <= (r_events & ~event_clr) | r_rise;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_MAX = LONG_WIDTH'(LONG_TICKS);
  localparam logic [LONG_WIDTH-1:0] LONG_PRE = LONG_WIDTH'(LONG_TICKS - 1);

  logic [TIMEOUT_WIDTH-1:0] r_presc;
  logic [LONG_WIDTH-1:0]    r_lcnt [WIDTH];
  logic [WIDTH-1:0]         r_long;
  logic                     w_tick;

  assign w_tick = (r_presc == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_long  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_lcnt[i] <= '0;
      end
    end else begin
      r_presc <= w_tick ? '0 : r_presc + TIMEOUT_WIDTH'(1);
      for (int i = 0; i < WIDTH; i++) begin
        r_long[i] <= 1'b0;
        if (!r_data[i]) begin
          r_lcnt[i] <= '0;
        end else if (w_tick && r_lcnt[i] != LONG_MAX) begin
          r_lcnt[i] <= r_lcnt[i] + LONG_WIDTH'(1);
          r_long[i] <= (r_lcnt[i] == LONG_PRE);
        end
      end
    end
  end

  assign long_pulse = r_long;
`else
  assign long_pulse = '0;
`endif

  assign data_out   = r_data;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign events     = r_events;
  assign irq        = |r_events;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (WIDTH=2, LOW polarity, TIMEOUT=4, LONG_TICKS=3).
// Cycle n is the interval after rising edge n; inputs change 1 ns after the edge, outputs are sampled on the falling edge.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] data_in;
  logic [1:0] event_clr;
  logic [1:0] data_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [1:0] long_pulse;
  logic [1:0] events;
  logic       irq;

  always #5 clk = ~clk;

  debounce_multi #(
    .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(4), .TIMEOUT_WIDTH(3),
    .LONG_TICKS(3), .LONG_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .event_clr(event_clr),
    .data_out(data_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_pulse(long_pulse), .events(events), .irq(irq)
  );

  typedef struct {
    logic [1:0] din;
    logic [1:0] clr;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] ev;
    logic       irq;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function void add(int n, logic [1:0] din, logic [1:0] clr, logic [1:0] out,
                    logic [1:0] rise, logic [1:0] fall, logic [1:0] ev, logic irq_e);
    vec_t v;
    v.din = din; v.clr = clr; v.out = out; v.rise = rise;
    v.fall = fall; v.ev = ev; v.irq = irq_e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int long_cnt;
    int long_idx;
    int first_rise;
    int first_fall;
    int fall_cycles;
    logic [1:0] fall_val;

    reset     = 1'b1;
    data_in   = 2'b11;
    event_clr = 2'b00;

    // c0-2: ch0 pressed, ch1 glitches low for 3 cycles; c6 ch0 press accepted
    add(3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(3,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add(1,  2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
    add(19, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
    // c26: release ch0 -> fall at c32, event stays sticky
    add(6,  2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
    add(1,  2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1);
    // c33: press again -> rise at c39 coincides with a clear; set wins
    add(6,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
    add(1,  2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
    add(1,  2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
    add(1,  2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
    add(2,  2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset data_out",   data_out,   2'b00);
    chk("reset rise_pulse", rise_pulse, 2'b00);
    chk("reset fall_pulse", fall_pulse, 2'b00);
    chk("reset long_pulse", long_pulse, 2'b00);
    chk("reset events",     events,     2'b00);
    chk("reset irq",        irq,        1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    long_cnt = 0;
    long_idx = -1;
    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk);
      #1;
      data_in   = tbl[r].din;
      event_clr = tbl[r].clr;
      @(negedge clk);
      chk($sformatf("row%0d data_out", r),   data_out,   tbl[r].out);
      chk($sformatf("row%0d rise_pulse", r), rise_pulse, tbl[r].rise);
      chk($sformatf("row%0d fall_pulse", r), fall_pulse, tbl[r].fall);
      chk($sformatf("row%0d events", r),     events,     tbl[r].ev);
      chk($sformatf("row%0d irq", r),        irq,        tbl[r].irq);
      if (long_pulse != 2'b00) begin
        long_cnt++;
        if (long_idx < 0) long_idx = r;
      end
`ifndef DEBOUNCE_LONG_PRESS_EN
      chk($sformatf("row%0d long_pulse", r), long_pulse, 2'b00);
`endif
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    chk("long_pulse count", long_cnt, 1);
    chk("long_pulse latency in 9..12", ((long_idx - 6) >= 9 && (long_idx - 6) <= 12), 1);
`else
    chk("long_pulse count", long_cnt, 0);
`endif

    // Reset aborts a press two counts in; a full 2+TIMEOUT is needed after release.
    @(posedge clk);
    #1;
    reset     = 1'b1;
    data_in   = 2'b11;
    event_clr = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 data_in = 2'b10;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre-abort data_out", data_out, 2'b00);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid-reset data_out", data_out, 2'b00);
    chk("mid-reset events",   events,   2'b00);
    chk("mid-reset irq",      irq,      1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    first_rise = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (rise_pulse[0] && first_rise < 0) first_rise = j;
      @(posedge clk);
    end
    chk("rise after reset release", first_rise, 6);
    #1;
    chk("events after reset press", events, 2'b01);

    // Press ch1 as well, then release both together.
    data_in = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("both pressed data_out", data_out, 2'b11);
    @(posedge clk);
    #1 data_in = 2'b11;
    first_fall  = -1;
    fall_cycles = 0;
    fall_val    = 2'b00;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (fall_pulse != 2'b00) begin
        fall_cycles++;
        if (first_fall < 0) begin
          first_fall = j;
          fall_val   = fall_pulse;
        end
      end
      @(posedge clk);
    end
    chk("joint release fall cycle",  first_fall,  6);
    chk("joint release fall value",  fall_val,    2'b11);
    chk("joint release fall count",  fall_cycles, 1);
    @(negedge clk);
    chk("joint release data_out",    data_out,    2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of independent input channels (1..32).
REQ-002 SHALL have parameter POLARITY, default "LOW": "LOW" means a channel is pressed when its input is 0; "HIGH" means pressed when its input is 1.
REQ-003 SHALL have parameter TIMEOUT, default 50000: stable cycles required before a state change is accepted (1 ms at 50 MHz); legal range is 2 or more.
REQ-004 SHALL have parameter TIMEOUT_WIDTH, default 16: counter width, at least ceil(log2(TIMEOUT)).
REQ-005 SHALL have parameter LONG_TICKS, default 500: held duration for a long press, counted in TIMEOUT periods; legal range is 1 or more.
REQ-006 SHALL have parameter LONG_WIDTH, default 10: long-press counter width, at least ceil(log2(LONG_TICKS+1)).
REQ-007 clk  input  1  clock; all flops on rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 data_in  input  WIDTH  raw asynchronous inputs (keys, switches).
REQ-010 event_clr  input  WIDTH  per-channel one-cycle clear of sticky event flags.
REQ-011 data_out  output  WIDTH  debounced state, normalised: 1 = pressed.
REQ-012 rise_pulse  output  WIDTH  one-cycle pulse on each debounced press.
REQ-013 fall_pulse  output  WIDTH  one-cycle pulse on each debounced release.
REQ-014 long_pulse  output  WIDTH  one-cycle pulse when a press is held for LONG_TICKS periods.
REQ-015 events  output  WIDTH  sticky press flags.
REQ-016 irq  output  1  level interrupt, equal to the OR of all bits of events.

Function
REQ-017 Each channel SHALL pass data_in through a 2-flop synchroniser, then apply POLARITY normalisation.
REQ-018 Per channel, when the synchronised value differs from data_out, the counter SHALL increment every cycle; when it equals data_out, the counter SHALL clear the same cycle.
REQ-019 When the counter reaches TIMEOUT-1 and the input still differs, data_out SHALL toggle on the next edge and the counter SHALL clear.
REQ-020 For a clean step held stable, data_out SHALL change exactly 2+TIMEOUT cycles after the data_in transition edge.
REQ-021 A glitch shorter than TIMEOUT synchronised cycles SHALL produce no change on any output.
REQ-022 rise_pulse[i] or fall_pulse[i] SHALL be high for exactly the single cycle in which data_out[i] first shows its new value; the two SHALL never be high together.
REQ-023 A free-running shared prescaler SHALL count 0..TIMEOUT-1 and emit a tick on TIMEOUT-1, then wrap to 0.
REQ-024 The per-channel long counter SHALL clear while data_out[i]=0 and increment on each tick while data_out[i]=1, saturating at LONG_TICKS.
REQ-025 long_pulse[i] SHALL assert for one cycle on the counter's transition to LONG_TICKS: once per press, latency from rise_pulse in [(LONG_TICKS-1)*TIMEOUT+1, LONG_TICKS*TIMEOUT] cycles.
REQ-026 events[i] SHALL set on rise_pulse[i] and clear on event_clr[i]; if both occur in the same cycle, set SHALL win.
REQ-027 irq SHALL be combinational from registered events (no additional latency).
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be reported in the same cycle.

Reset
REQ-029 While reset is high: data_out, all pulses, events, irq, counters and prescaler SHALL be 0; synchroniser flops SHALL hold the released input level (1 for "LOW", 0 for "HIGH").
REQ-030 Reset asserted mid-count or mid-press SHALL abort it; after release no pulse SHALL occur unless input remains pressed for a full 2+TIMEOUT cycles.
REQ-031 Reset deassertion SHALL be honoured synchronously to clk; the first counting edge is the first edge after release.

Configuration
REQ-032 With macro DEBOUNCE_LONG_PRESS_EN defined, the prescaler, long counters and long_pulse logic SHALL be built per REQ-023 to REQ-025.
REQ-033 Without DEBOUNCE_LONG_PRESS_EN, long_pulse SHALL be constant 0, no prescaler or long counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification (WIDTH=2, POLARITY="LOW", TIMEOUT=4, LONG_TICKS=3)
REQ-034 Set data_in[0] from 1 to 0 at cycle 0 and hold -> data_out[0]=1 and rise_pulse[0]=1 at cycle 6 only; events[0]=1 and irq=1 from cycle 7.
REQ-035 Drive data_in[1] low for 3 cycles, then high -> no output change on channel 1 for 20 cycles.
REQ-036 Hold channel 0 pressed for 20 cycles (macro defined) -> exactly one long_pulse[0], 9 to 12 cycles after rise_pulse[0]; with the macro undefined, long_pulse stays 0.
REQ-037 With events[0]=1, assert event_clr[0] in the same cycle as a new rise_pulse[0] -> events[0] stays 1; event_clr[0] alone -> events[0]=0 and irq=0 on the next cycle.
REQ-038 Assert reset 2 cycles into a press count, release it, and keep the input pressed -> rise_pulse[0] occurs 2+4 cycles after release, not earlier.
REQ-039 Release both channels on the same edge -> fall_pulse=2'b11 in one cycle, and data_out=2'b00 from then on.
